iob_ptfloat_fpu_arb: RTL and testbench
======================================

// Module: iob_ptfloat_fpu_arb
// PURPOSE
//  Shares one iob_ptfloat_fpu among N_REQ requesters. Round-robin arbitration,
//  valid/ready handshake per requester. Latches the winner's opcode and operands
//  and holds them stable on the FPU inputs for the whole operation. Captures the
//  result and flags on fpu_done_i, then returns them to the winner only.
//  Sits between the CPU/accelerator ports and the FPU.
// PARAMETERS
//  DATA_W      32   operand/result width; equals FPU DATA_W
//  N_REQ       2    number of requesters, 2..8
//  TIMEOUT_W   8    watchdog counter width (used only with the macro)
// PORTS
//  clk_i             in   1                clock
//  arst_i            in   1                async reset, active-high
//  cke_i             in   1                clock enable; all state holds when 0
//  req_valid_i       in   N_REQ            per-requester request valid
//  req_ready_o       out  N_REQ            one-hot accept pulse
//  req_op_i          in   N_REQ*OPCODE_W   packed opcodes, requester i at [i*OPCODE_W+:OPCODE_W]
//  req_op1_i         in   N_REQ*DATA_W     packed operand 1
//  req_op2_i         in   N_REQ*DATA_W     packed operand 2
//  rsp_valid_o       out  N_REQ            one-hot: result pending for requester i
//  rsp_ready_i       in   N_REQ            requester accepts result
//  rsp_data_o        out  DATA_W           result (shared bus, valid under rsp_valid_o)
//  rsp_flags_o       out  4                {timeout, div_by_zero, underflow, overflow}
//  fpu_op_o          out  OPCODE_W         to FPU op_i
//  fpu_start_o       out  1                to FPU start_i
//  fpu_op1_o         out  DATA_W           to FPU op1_i
//  fpu_op2_o         out  DATA_W           to FPU op2_i
//  fpu_done_i        in   1                from FPU done_o
//  fpu_data_i        in   DATA_W           from FPU data_o
//  fpu_ovf_i         in   1                from FPU overflow_o
//  fpu_unf_i         in   1                from FPU underflow_o
//  fpu_dbz_i         in   1                from FPU div_by_zero_o
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, all outputs 0 (data, flags, op, operands).
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if any req_valid_i, grant first valid index at or after the rr pointer
//    (wrapping N_REQ-1 -> 0); req_ready_o[g]=1 for that one cycle; latch g, op,
//    op1, op2; rr pointer <= g+1 mod N_REQ. Go ISSUE. No valid: stay, ready=0.
//  - ISSUE: fpu_start_o=1 for exactly one cycle; go WAIT.
//  - WAIT: fpu_op_o/op1/op2 held constant; on fpu_done_i capture fpu_data_i and
//    {0,dbz,unf,ovf} into result regs (div_by_zero sampled only here); go RESP.
//  - RESP: rsp_valid_o[g]=1, data/flags stable; on rsp_ready_i[g] go IDLE.
//    rsp_ready_i of other indices ignored. New grant earliest the cycle after.
//  - Throughput: one operation in flight; grant-to-start latency 1 cycle;
//    rsp_valid_o rises 1 cycle after fpu_done_i.
//  - Requester dropping req_valid_i after grant: no effect (already latched).
//  - fpu_done_i outside WAIT is ignored.
//  - Reset mid-operation: FSM to IDLE, pending result discarded; fpu_start_o
//    never asserts spuriously after reset release.
//  - cke_i=0 freezes FSM, pointer and registers; req_ready_o and fpu_start_o
//    are forced 0 while cke_i=0.
// CONFIGURATION
//  - PTFLOAT_ARB_TIMEOUT_EN defined: TIMEOUT_W-bit counter cleared at ISSUE,
//    increments each WAIT cycle; on reaching all-ones without fpu_done_i, go
//    RESP with rsp_data_o=0, rsp_flags_o=4'b1000. A done in that same cycle
//    takes priority (normal capture, timeout=0).
//  - Not defined: no counter; WAIT lasts until fpu_done_i; flags[3] tied 0.
// TESTING (bench uses a behavioural FPU: done after 5 cycles, data=op1^op2)
//  - Reset: all outputs 0, state IDLE; release with no requests -> no ready/start.
//  - Single req0 op1=0x0000_00F0 op2=0x0000_000F -> ready pulse, start 1 cycle
//    later, rsp_valid_o=01, rsp_data_o=0x0000_00FF; held until rsp_ready_i[0].
//  - req0,req1 valid continuously (N_REQ=2) -> grants alternate 0,1,0,1;
//    each rsp only to its own index.
//  - Model pulses div_by_zero with done -> rsp_flags_o=4'b0100; op/operands
//    on FPU side constant for entire WAIT (assertion).
//  - arst_i during WAIT -> IDLE, no rsp_valid_o; next request served normally.
//  - With PTFLOAT_ARB_TIMEOUT_EN, TIMEOUT_W=4, model never done -> after 15
//    WAIT cycles rsp_flags_o=4'b1000, rsp_data_o=0.

Source files
------------

// File: rtl/iob_ptfloat_fpu_arb.sv
// Round-robin arbiter sharing one iob_ptfloat_fpu between N_REQ requesters.
// Optional FPU watchdog enabled by defining PTFLOAT_ARB_TIMEOUT_EN.
module iob_ptfloat_fpu_arb #(
  parameter int DATA_W    = 32,
  parameter int N_REQ     = 2,
  parameter int OPCODE_W  = 3,
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       cke_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*OPCODE_W-1:0]  req_op_i,
  input  logic [N_REQ*DATA_W-1:0]    req_op1_i,
  input  logic [N_REQ*DATA_W-1:0]    req_op2_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  input  logic [N_REQ-1:0]           rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [3:0]                 rsp_flags_o,
  output logic [OPCODE_W-1:0]        fpu_op_o,
  output logic                       fpu_start_o,
  output logic [DATA_W-1:0]          fpu_op1_o,
  output logic [DATA_W-1:0]          fpu_op2_o,
  input  logic                       fpu_done_i,
  input  logic [DATA_W-1:0]          fpu_data_i,
  input  logic                       fpu_ovf_i,
  input  logic                       fpu_unf_i,
  input  logic                       fpu_dbz_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_reg, rr_next;
  logic [IDX_W-1:0]    grant_reg, grant_next;
  logic [OPCODE_W-1:0] op_reg, op_next;
  logic [DATA_W-1:0]   op1_reg, op1_next;
  logic [DATA_W-1:0]   op2_reg, op2_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [3:0]          flags_reg, flags_next;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W:0]      scan_idx;
  logic                pick_found;
  logic                grant_fire;
`ifdef PTFLOAT_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer_reg, timer_next;
`endif

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick       = rr_reg;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_reg} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(N_REQ))
        scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
      if (!pick_found && req_valid_i[scan_idx[IDX_W-1:0]]) begin
        pick       = scan_idx[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    grant_next = grant_reg;
    op_next    = op_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    data_next  = data_reg;
    flags_next = flags_reg;
    grant_fire = 1'b0;
`ifdef PTFLOAT_ARB_TIMEOUT_EN
    timer_next = timer_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_fire = 1'b1;
          grant_next = pick;
          op_next    = req_op_i[pick*OPCODE_W +: OPCODE_W];
          op1_next   = req_op1_i[pick*DATA_W +: DATA_W];
          op2_next   = req_op2_i[pick*DATA_W +: DATA_W];
          rr_next    = (pick == IDX_W'(N_REQ-1)) ? '0 : pick + 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
`ifdef PTFLOAT_ARB_TIMEOUT_EN
        timer_next = '0;
`endif
      end
      WAIT: begin
`ifdef PTFLOAT_ARB_TIMEOUT_EN
        timer_next = timer_reg + 1'b1;
`endif
        if (fpu_done_i) begin
          data_next  = fpu_data_i;
          flags_next = {1'b0, fpu_dbz_i, fpu_unf_i, fpu_ovf_i};
          state_next = RESP;
        end
`ifdef PTFLOAT_ARB_TIMEOUT_EN
        // A done arriving on the expiry cycle wins over the timeout.
        else if (&timer_next) begin
          data_next  = '0;
          flags_next = 4'b1000;
          state_next = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i[grant_reg])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg <= IDLE;
      rr_reg    <= '0;
      grant_reg <= '0;
      op_reg    <= '0;
      op1_reg   <= '0;
      op2_reg   <= '0;
      data_reg  <= '0;
      flags_reg <= '0;
`ifdef PTFLOAT_ARB_TIMEOUT_EN
      timer_reg <= '0;
`endif
    end else if (cke_i) begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      grant_reg <= grant_next;
      op_reg    <= op_next;
      op1_reg   <= op1_next;
      op2_reg   <= op2_next;
      data_reg  <= data_next;
      flags_reg <= flags_next;
`ifdef PTFLOAT_ARB_TIMEOUT_EN
      timer_reg <= timer_next;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_port
      assign req_ready_o[gi] = cke_i && grant_fire && (pick == IDX_W'(gi));
      assign rsp_valid_o[gi] = (state_reg == RESP) && (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign fpu_start_o = cke_i && (state_reg == ISSUE);
  assign fpu_op_o    = op_reg;
  assign fpu_op1_o   = op1_reg;
  assign fpu_op2_o   = op2_reg;
  assign rsp_data_o  = data_reg;
  assign rsp_flags_o = flags_reg;

endmodule

// File: tb/tb_iob_ptfloat_fpu_arb.sv
// Directed bench for iob_ptfloat_fpu_arb with a behavioural FPU
// (done 5 cycles after start, data = op1 ^ op2).
module tb_iob_ptfloat_fpu_arb;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cke = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_op = '0;
  logic [63:0] req_op1 = '0;
  logic [63:0] req_op2 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [2:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_op1, fpu_op2;
  logic        fpu_done;
  logic [31:0] fpu_data;
  logic        fpu_ovf, fpu_unf, fpu_dbz;

  int          n_total = 0;
  int          n_pass  = 0;
  int          busy_cnt = 0;
  int          start_cnt = 0;
  logic [2:0]  fl_mode = '0;
  logic        never_done = 1'b0;

  always #5 clk = ~clk;

  iob_ptfloat_fpu_arb #(
    .DATA_W(32), .N_REQ(2), .OPCODE_W(3), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_op1_i(req_op1), .req_op2_i(req_op2),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags),
    .fpu_op_o(fpu_op), .fpu_start_o(fpu_start),
    .fpu_op1_o(fpu_op1), .fpu_op2_o(fpu_op2),
    .fpu_done_i(fpu_done), .fpu_data_i(fpu_data),
    .fpu_ovf_i(fpu_ovf), .fpu_unf_i(fpu_unf), .fpu_dbz_i(fpu_dbz)
  );

  // Behavioural FPU
  always @(posedge clk) begin
    if (fpu_start) busy_cnt <= 5;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (fpu_start) start_cnt <= start_cnt + 1;
  end
  assign fpu_done = (busy_cnt == 1) && !never_done;
  assign fpu_data = fpu_op1 ^ fpu_op2;
  assign {fpu_dbz, fpu_unf, fpu_ovf} = fpu_done ? fl_mode : 3'b000;

  typedef struct {
    logic [1:0]  valid;
    logic        keep;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  fl;       // {dbz, unf, ovf} pulsed with done
    int          grant;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive_req(input logic [1:0] valid, input int g, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    req_valid = valid;
    for (int i = 0; i < 2; i++) begin
      req_op[i*3 +: 3]   = (i == g) ? op : ~op;
      req_op1[i*32 +: 32] = (i == g) ? a : (a ^ 32'h5A5A_0000);
      req_op2[i*32 +: 32] = (i == g) ? b : ~b;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] g_oh;
    int         lat;
    logic       hold_ok;
    g_oh = 2'b01 << v.grant;
    @(negedge clk);
    fl_mode = v.fl;
    drive_req(v.valid, v.grant, v.op, v.a, v.b);
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(g_oh));
    @(posedge clk); #1;
    check({tag, "_start"}, 32'(fpu_start), 32'd1);
    check({tag, "_fpu_op1"}, fpu_op1, v.a);
    check({tag, "_fpu_op2"}, fpu_op2, v.b);
    check({tag, "_fpu_op"}, 32'(fpu_op), 32'(v.op));
    // Scramble request side; the FPU side must stay latched.
    if (!v.keep) req_valid = 2'b00;
    req_op1 = '1;
    req_op2 = '1;
    req_op  = '1;
    lat = 0;
    hold_ok = 1'b1;
    while (rsp_valid == 2'b00 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (lat >= 2 && fpu_start) hold_ok = 1'b0;
      if (fpu_op1 !== v.a || fpu_op2 !== v.b || fpu_op !== v.op) hold_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'd7);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(g_oh));
    check({tag, "_rsp_data"}, rsp_data, v.exp_data);
    check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'(v.exp_flags));
    rsp_ready = ~g_oh;
    @(negedge clk);
    check({tag, "_other_ready_ignored"}, 32'(rsp_valid), 32'(g_oh));
    rsp_ready = g_oh;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
    rsp_ready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s0;
    int   lat;
    logic seen;
    vec_t post;

    vecs[0] = '{2'b01, 1'b0, 3'd1, 32'h0000_00F0, 32'h0000_000F, 3'b000, 0, 32'h0000_00FF, 4'b0000};
    vecs[1] = '{2'b11, 1'b1, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 3'b000, 1, 32'h1D3B_5977, 4'b0000};
    vecs[2] = '{2'b11, 1'b1, 3'd3, 32'hFFFF_0000, 32'h00FF_FF00, 3'b000, 0, 32'hFF00_FF00, 4'b0000};
    vecs[3] = '{2'b11, 1'b1, 3'd4, 32'hAAAA_AAAA, 32'h5555_5555, 3'b000, 1, 32'hFFFF_FFFF, 4'b0000};
    vecs[4] = '{2'b10, 1'b0, 3'd5, 32'h0000_0001, 32'h0000_0001, 3'b001, 1, 32'h0000_0000, 4'b0001};
    vecs[5] = '{2'b01, 1'b0, 3'd3, 32'h3F80_0000, 32'h0000_0000, 3'b100, 0, 32'h3F80_0000, 4'b0100};
    vecs[6] = '{2'b01, 1'b0, 3'd0, 32'h8000_0000, 32'h0000_0001, 3'b010, 0, 32'h8000_0001, 4'b0010};
    post    = '{2'b11, 1'b0, 3'd6, 32'h0000_FFFF, 32'hFFFF_0000, 3'b000, 0, 32'hFFFF_FFFF, 4'b0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_fpu_start", 32'(fpu_start), 32'd0);
    check("rst_fpu_op", 32'(fpu_op), 32'd0);
    check("rst_fpu_op1", fpu_op1, 32'd0);
    check("rst_fpu_op2", fpu_op2, 32'd0);
    arst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_ready", 32'(req_ready), 32'd0);
    check("idle_no_start", 32'(start_cnt), 32'd0);

    // Clock enable low freezes the arbiter
    cke = 1'b0;
    drive_req(2'b10, 1, 3'd7, 32'h1, 32'h2);
    #1 check("cke_ready_forced", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("cke_no_start", 32'(start_cnt), 32'd0);
    check("cke_no_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;
    cke = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset during WAIT discards the pending operation
    @(negedge clk);
    fl_mode = 3'b000;
    drive_req(2'b01, 0, 3'd2, 32'h0000_0011, 32'h0000_0022);
    @(posedge clk); #1;
    check("rstwait_start", 32'(fpu_start), 32'd1);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1;
    check("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwait_fpu_op1", fpu_op1, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    s0 = start_cnt;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check("rstwait_no_rsp", 32'(seen), 32'd0);
    check("rstwait_no_start", 32'(start_cnt - s0), 32'd0);
    run_vec(post, "post_rst");

`ifdef PTFLOAT_ARB_TIMEOUT_EN
    never_done = 1'b1;
    @(negedge clk);
    drive_req(2'b01, 0, 3'd1, 32'h0000_1234, 32'h0000_4321);
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    while (rsp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("tmo_latency", 32'(lat), 32'd17);
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_rsp_data", rsp_data, 32'd0);
    check("tmo_rsp_flags", 32'(rsp_flags), 32'h8);
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    never_done = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
